// File: rtl/div_ctrl_if.sv
// Handshake bundle between the divide sequencer and the shared iterative divider.
// The master side launches operands and accepts results; the slave side is the divider.
interface div_ctrl_if #(
  parameter int DATA_WD = 32
);

  // launch channel: sequencer -> divider
  logic               div_in_valid;
  logic               div_in_signed;
  logic [DATA_WD-1:0] div_in_dividend;
  logic [DATA_WD-1:0] div_in_divisor;
  logic               div_in_ready;

  // result channel: divider -> sequencer
  logic               div_out_valid;
  logic [DATA_WD-1:0] div_out_quot;
  logic [DATA_WD-1:0] div_out_rem;
  logic               div_out_ready;

  modport master (
    output div_in_valid,
    output div_in_signed,
    output div_in_dividend,
    output div_in_divisor,
    input  div_in_ready,
    input  div_out_valid,
    input  div_out_quot,
    input  div_out_rem,
    output div_out_ready
  );

  modport slave (
    input  div_in_valid,
    input  div_in_signed,
    input  div_in_dividend,
    input  div_in_divisor,
    output div_in_ready,
    output div_out_valid,
    output div_out_quot,
    output div_out_rem,
    input  div_out_ready
  );

endinterface

// File: rtl/div_ctrl.sv
// Sequencer between the EXE stage and the shared iterative divider.
// One divide is launched per DIV/DIVU resident in EXE; EXE is held until the result
// is back, HI/LO are written only when the instruction actually leaves EXE, and a
// divide killed by a flush is drained so its stale result never reaches HI/LO.
module div_ctrl #(
  parameter int DATA_WD     = 32,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,

  // EXE stage side
  input  logic               es_div_req,
  input  logic               es_div_signed,
  input  logic [DATA_WD-1:0] es_dividend,
  input  logic [DATA_WD-1:0] es_divisor,
  input  logic               es_leave,
  input  logic               flush,
  output logic               div_ready_go,
  output logic               div_busy,

  // HI/LO write port
  output logic               hi_we,
  output logic               lo_we,
  output logic [DATA_WD-1:0] hi_wdata,
  output logic [DATA_WD-1:0] lo_wdata,

  // divider side
  div_ctrl_if.master         div_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               op_signed;
  logic [DATA_WD-1:0] op_dividend;
  logic [DATA_WD-1:0] op_divisor;
  logic [DATA_WD-1:0] res_quot;
  logic [DATA_WD-1:0] res_rem;

  logic               latch_ops;
  logic               bypass_hit;
  logic               capture_res;
  logic               commit;
  logic               divisor_zero;

  // divisor==0 only short-circuits the divider when the bypass is built in
  assign divisor_zero = ZERO_BYPASS && (es_divisor == '0);

  // next-state decode; flush always wins over a pending leave or result
  always_comb begin
    state_nxt   = state;
    latch_ops   = 1'b0;
    bypass_hit  = 1'b0;
    capture_res = 1'b0;
    commit      = 1'b0;
    case (state)
      S_IDLE: begin
        if (es_div_req && !flush) begin
          latch_ops = 1'b1;
          if (divisor_zero) begin
            bypass_hit = 1'b1;
            state_nxt  = S_DONE;
          end else begin
            state_nxt  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (div_bus.div_in_ready) begin
          state_nxt = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (div_bus.div_out_valid) begin
          if (flush) begin
            state_nxt = S_IDLE;
          end else begin
            capture_res = 1'b1;
            state_nxt   = S_DONE;
          end
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (es_leave) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (div_bus.div_out_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // operand latch: held stable for the whole launch so the divider sees one value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_signed   <= 1'b0;
      op_dividend <= '0;
      op_divisor  <= '0;
    end else if (latch_ops) begin
      op_signed   <= es_div_signed;
      op_dividend <= es_dividend;
      op_divisor  <= es_divisor;
    end
  end

  // result latch: loaded by the zero-divisor bypass or by an accepted divider result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_quot <= '0;
      res_rem  <= '0;
    end else if (bypass_hit) begin
      res_quot <= {DATA_WD{1'b1}};
      res_rem  <= es_dividend;
    end else if (capture_res) begin
      res_quot <= div_bus.div_out_quot;
      res_rem  <= div_bus.div_out_rem;
    end
  end

  assign div_bus.div_in_valid    = (state == S_ISSUE);
  assign div_bus.div_in_signed   = op_signed;
  assign div_bus.div_in_dividend = op_dividend;
  assign div_bus.div_in_divisor  = op_divisor;
  assign div_bus.div_out_ready   = (state == S_WAIT) || (state == S_DRAIN);

  assign div_ready_go = (state == S_DONE);
  assign div_busy     = (state != S_IDLE);

  assign hi_we    = commit;
  assign lo_we    = commit;
  assign hi_wdata = res_rem;
  assign lo_wdata = res_quot;

endmodule
